// File: rtl/musa_pkg.sv
// Shared MUSA core definitions: PC width, default return-stack depth and the PC type.
package musa_pkg;

  localparam int unsigned PC_W      = 18;
  localparam int unsigned RAS_DEPTH = 16;

  typedef logic [PC_W-1:0] pc_t;

endpackage

// File: rtl/call_stack_ram.sv
// Return-stack storage: DEPTH x ADDR_W register array, one synchronous write port and
// one asynchronous read port. Contents are never reset.
module call_stack_ram
  import musa_pkg::*;
#(
  parameter int unsigned ADDR_W = PC_W,
  parameter int unsigned DEPTH  = RAS_DEPTH,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [ADDR_W-1:0] rdata
);

  logic [ADDR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack.sv
// Return-address stack with occupancy reporting, tail-call replace and sticky error flags.
// Define CALL_STACK_WRAP_EN for circular mode (push while full overwrites the oldest entry).
module call_stack
  import musa_pkg::*;
#(
  parameter int unsigned ADDR_W = PC_W,
  parameter int unsigned DEPTH  = RAS_DEPTH,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] top_addr,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);

  logic [CNT_W-1:0]  wp_q, wp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [CNT_W-1:0]  top_idx, wp_inc;
  logic              we;
  logic [CNT_W-1:0]  waddr;
  logic [ADDR_W-1:0] rdata;

  // Explicit wrap compares so non-power-of-two depths work.
  assign top_idx = (wp_q == '0) ? LastIdx : wp_q - CNT_W'(1);
  assign wp_inc  = (wp_q == LastIdx) ? '0 : wp_q + CNT_W'(1);

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == FullCnt);
  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign top_addr  = empty ? '0 : rdata;

  always_comb begin
    wp_d  = wp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q & ~clr_err;
    unf_d = unf_q & ~clr_err;
    we    = 1'b0;
    waddr = wp_q;

    if (push && pop && !empty) begin
      // Tail call: replace the top entry in place.
      we    = 1'b1;
      waddr = top_idx;
    end else if (push) begin
      if (!full) begin
        we    = 1'b1;
        wp_d  = wp_inc;
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        ovf_d = 1'b1;
`ifdef CALL_STACK_WRAP_EN
        // When full, wp points at the oldest entry, which is sacrificed.
        we    = 1'b1;
        wp_d  = wp_inc;
`endif
      end
    end else if (pop) begin
      if (!empty) begin
        wp_d  = top_idx;
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  call_stack_ram #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr[IDX_W-1:0]),
    .wdata (push_addr),
    .raddr (top_idx[IDX_W-1:0]),
    .rdata (rdata)
  );

endmodule
